// File: rtl/apb_master_bridge.sv
// Request-to-APB master bridge: one APB transfer per accepted request.
// The bridge sequences SETUP and ACCESS, and a timeout aborts an ACCESS phase that stalls.
module apb_master_bridge #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_tmo,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  // Keep the counter at least 1 bit wide when the timeout is disabled.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic              req_ready_d, rsp_valid_d, rsp_err_d, rsp_tmo_d;
  logic              pwrite_d, psel_d, penable_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d, rsp_rdata_d;
  logic              timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    req_ready_d = req_ready;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    rsp_tmo_d   = rsp_tmo;
    paddr_d     = paddr;
    pwrite_d    = pwrite;
    pwdata_d    = pwdata;
    psel_d      = psel;
    penable_d   = penable;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_d     = SETUP;
          req_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          paddr_d     = req_addr;
          pwrite_d    = req_write;
          pwdata_d    = req_wdata;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (pready) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_tmo_d   = 1'b0;
          rsp_rdata_d = (pwrite || pslverr) ? '0 : prdata;
        end else if (timeout_hit) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_tmo_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rsp_tmo   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      rsp_tmo   <= rsp_tmo_d;
      paddr     <= paddr_d;
      pwrite    <= pwrite_d;
      pwdata    <= pwdata_d;
      psel      <= psel_d;
      penable   <= penable_d;
    end
  end

endmodule
